// File: rtl/decim4_fir.sv
// Decimate-by-4 8-tap symmetric low-pass FIR: one output per four accepted samples,
// computed on a 4-cycle pre-add/MAC datapath. Define DECIM4_SAT_EN to saturate the output.
module decim4_fir (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] xin,
    input  logic        xin_valid,
    input  logic        phase_clr,
    output logic [13:0] yout,
    output logic        yout_valid,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3} state_t;

    state_t             state;
    state_t             state_next;
    logic signed [13:0] d [0:7];
    logic signed [13:0] s [0:7];
    logic [1:0]         ph;
    logic [1:0]         ph_eff;
    logic               trigger;
    logic signed [24:0] acc;
    logic signed [24:0] acc_sum;
    logic signed [24:0] coef;
    logic signed [13:0] tap_a;
    logic signed [13:0] tap_b;
    logic signed [14:0] pre_add;
    logic signed [24:0] pre_ext;
    logic signed [24:0] prod;
    logic signed [24:0] res;
    logic [13:0]        y_lim;

    // A sample arriving with phase_clr is phase 0, so it can never be the trigger.
    assign ph_eff  = phase_clr ? 2'd0 : ph;
    assign trigger = xin_valid && (ph_eff == 2'd3);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 2'd0;
            for (int i = 0; i < 8; i++) d[i] <= '0;
        end else begin
            if (xin_valid) begin
                ph   <= ph_eff + 2'd1;
                d[0] <= xin;
                for (int i = 1; i < 8; i++) d[i] <= d[i-1];
            end else if (phase_clr) begin
                ph <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) s[i] <= '0;
        end else if (trigger) begin
            s[0] <= xin;
            for (int i = 1; i < 8; i++) s[i] <= d[i-1];
        end
    end

    // Tap pair and coefficient for the current MAC step: step k uses hk*(s(7-k)+s(k)).
    always_comb begin
        coef  = '0;
        tap_a = '0;
        tap_b = '0;
        case (state)
            MAC0: begin coef = -25'sd20;  tap_a = s[7]; tap_b = s[0]; end
            MAC1: begin coef = 25'sd40;   tap_a = s[6]; tap_b = s[1]; end
            MAC2: begin coef = 25'sd196;  tap_a = s[5]; tap_b = s[2]; end
            MAC3: begin coef = 25'sd296;  tap_a = s[4]; tap_b = s[3]; end
            default: ;
        endcase
    end

    assign pre_add = {tap_a[13], tap_a} + {tap_b[13], tap_b};
    assign pre_ext = {{10{pre_add[14]}}, pre_add};
    assign prod    = coef * pre_ext;
    assign acc_sum = acc + prod;
    assign res     = acc_sum >>> 10;

`ifdef DECIM4_SAT_EN
    always_comb begin
        if (res > 25'sd8191)
            y_lim = 14'h1fff;
        else if (res < -25'sd8192)
            y_lim = 14'h2000;
        else
            y_lim = res[13:0];
    end
`else
    assign y_lim = res[13:0];
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = MAC0;
            MAC0:    state_next = MAC1;
            MAC1:    state_next = MAC2;
            MAC2:    state_next = MAC3;
            MAC3:    state_next = trigger ? MAC0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A same-edge trigger at MAC3 still registers the finished result before acc restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            yout       <= '0;
            yout_valid <= 1'b0;
        end else begin
            yout_valid <= (state == MAC3);
            if (state == MAC3) yout <= y_lim;
            if (trigger)
                acc <= '0;
            else if (state != IDLE)
                acc <= acc_sum;
        end
    end

endmodule

// File: tb/tb_decim4_fir.sv
// Scoreboard bench for decim4_fir: the driver pushes expected outputs and cycles,
// a negedge monitor pops and compares; directed hand values are checked per test.
module tb_decim4_fir;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] xin = '0;
    logic        xin_valid = 1'b0;
    logic        phase_clr = 1'b0;
    logic [13:0] yout;
    logic        yout_valid;
    logic        busy;

    decim4_fir dut (
        .clk        (clk),
        .rst        (rst),
        .xin        (xin),
        .xin_valid  (xin_valid),
        .phase_clr  (phase_clr),
        .yout       (yout),
        .yout_valid (yout_valid),
        .busy       (busy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [13:0] exp_q[$];
    int          cyc_q[$];
    int          got_q[$];

    int h [8] = '{-20, 40, 196, 296, 296, 196, 40, -20};
    int md[8];
    int mph = 0;
    int last_trig = -100;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] model_out();
        int sum;
        int q;
        logic [31:0] qv;
        sum = 0;
        for (int i = 0; i < 8; i++) sum += h[i] * md[i];
        q = sum >>> 10;
`ifdef DECIM4_SAT_EN
        if (q > 8191) q = 8191;
        if (q < -8192) q = -8192;
`endif
        qv = q;
        return qv[13:0];
    endfunction

    // driver tasks
    task automatic send(input int x, input bit clr);
        int eff;
        xin       = 14'(x);
        xin_valid = 1'b1;
        phase_clr = clr;
        @(posedge clk);
        #1;
        xin_valid = 1'b0;
        phase_clr = 1'b0;
        for (int i = 7; i > 0; i--) md[i] = md[i-1];
        md[0] = x;
        eff = clr ? 0 : mph;
        if (eff == 3) begin
            if (last_trig >= 0) check("trig_spacing", ((cyc - last_trig) >= 4) ? 1 : 0, 1);
            exp_q.push_back(model_out());
            cyc_q.push_back(cyc + 4);
            last_trig = cyc;
        end
        mph = (eff + 1) % 4;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_only();
        phase_clr = 1'b1;
        @(posedge clk);
        #1;
        phase_clr = 1'b0;
        mph = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        xin_valid = 1'b0;
        phase_clr = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) md[i] = 0;
        mph = 0;
        last_trig = -100;
        #1;
        check("rst_yout", int'(yout), 0);
        check("rst_yout_valid", int'(yout_valid), 0);
        check("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            idle(1);
        end
        check("drain_timeout", exp_q.size(), 0);
        idle(1);
    endtask

    task automatic check_got(input string name, input int idx, input int exp);
        if (got_q.size() <= idx)
            check(name, -99999, exp);
        else
            check(name, got_q[idx], exp);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && yout_valid) begin
            got_q.push_back(int'($signed(yout)));
            if (exp_q.size() == 0) begin
                check("unexpected_yout_valid", 1, 0);
            end else begin
                check("yout", int'($signed(yout)), int'($signed(exp_q.pop_front())));
                check("latency", cyc, cyc_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle(1);

        // DC stream, valid every clock; busy must stay high once running
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(1000, 1'b0);
            if (i >= 3) check("busy_stream", int'(busy), 1);
        end
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("busy_tail", int'(busy), 1);
        end
        idle(1);
        check("busy_drop", int'(busy), 0);
        drain();
        check_got("dc_out1", 0, 500);
        check_got("dc_out2", 1, 1000);
        check_got("dc_out3", 2, 1000);

        // impulse with idle gaps between samples
        do_reset();
        send(1000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            send(0, 1'b0);
        end
        drain();
        check_got("imp_out1", 0, 289);
        check_got("imp_out2", 1, -20);

        // phase realign on 3rd valid: trigger moves to 6th valid
        do_reset();
        send(100, 1'b0);
        send(200, 1'b0);
        send(300, 1'b1);
        send(400, 1'b0);
        idle(6);
        check("realign_no_early", got_q.size(), 0);
        send(500, 1'b0);
        send(600, 1'b0);
        drain();
        check("realign_count", got_q.size(), 1);
        check_got("realign_out1", 0, 248);

        // overflow pattern
        do_reset();
        send(-8192, 1'b0);
        for (int i = 0; i < 6; i++) send(8191, 1'b0);
        send(-8192, 1'b0);
        drain();
        check_got("ovf_out1", 0, -641);
`ifdef DECIM4_SAT_EN
        check_got("ovf_out2", 1, 8191);
`else
        check_got("ovf_out2", 1, -7554);
`endif

        // phase_clr while the MAC runs only touches the phase
        do_reset();
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b0);
        send(40, 1'b0);
        send(50, 1'b0);
        clr_only();
        for (int i = 0; i < 4; i++) send(60 + i * 10, 1'b0);
        drain();
        check_got("clr_mac_out1", 0, 7);
        check("clr_mac_count", got_q.size(), 2);

        // reset in the middle of a MAC sequence
        do_reset();
        for (int i = 0; i < 4; i++) send(1000, 1'b0);
        idle(1);
        do_reset();
        idle(6);
        check("midrst_no_out", got_q.size(), 0);
        check("midrst_yout", int'(yout), 0);
        for (int i = 0; i < 4; i++) send(1000, 1'b0);
        drain();
        check_got("midrst_out1", 0, 500);

        check("leftover_exp", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
